// File: rtl/sram_fault_responder_pkg.sv
// Shared defaults and encodings for the BIST-facing SRAM responder with fault injection.
package sram_fault_responder_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 4;
  localparam int DEPTH      = 1 << DEF_ADDR_W;

  typedef enum logic [2:0] {
    FT_NONE = 3'd0,
    FT_SA0  = 3'd1,
    FT_SA1  = 3'd2,
    FT_TFUP = 3'd3,
    FT_CFIN = 3'd4
  } fault_type_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

endpackage

// File: rtl/sram_fault_responder_if.sv
// BIST <-> memory request/response bus.
interface sram_fault_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic              mem_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;

  modport master (output mem_en, wr_en, addr, data_in,
                  input  data_out, rd_valid, busy);
  modport slave  (input  mem_en, wr_en, addr, data_in,
                  output data_out, rd_valid, busy);
endinterface

// File: rtl/sram_fault_responder_array.sv
// Plain single-port RAM with an extra read/write port dedicated to the fault victim word.
module sram_fault_responder_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk_sys,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic              vwe,
  input  logic [ADDR_W-1:0] vaddr,
  input  logic [DATA_W-1:0] vdin,
  output logic [DATA_W-1:0] vdout
);
  localparam int WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [WORDS];

  // Both ports never target the same word in one cycle; the controller guarantees it.
  always_ff @(posedge clk_sys) begin
    if (we)  mem[addr]  <= din;
    if (vwe) mem[vaddr] <= vdin;
  end

  assign dout  = mem[addr];
  assign vdout = mem[vaddr];
endmodule

// File: rtl/sram_fault_responder.sv
// SRAM target for the March BIST: clears itself after reset and injects one programmable cell fault.
//  state   | meaning
//  ST_INIT | clearing sweep, one word per cycle, bus requests ignored (busy=1)
//  ST_IDLE | servicing reads/writes, fault registers loadable
module sram_fault_responder
  import sram_fault_responder_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  sram_fault_responder_if.slave  bus,
  input  logic                   fault_load,
  input  logic [2:0]             fault_type,
  input  logic [ADDR_W-1:0]      fault_addr,
  input  logic [1:0]             fault_bit,
  input  logic [ADDR_W-1:0]      aggr_addr,
  output logic [CNT_W-1:0]       wr_count,
  output logic [CNT_W-1:0]       rd_count
);
  state_e            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;

  fault_type_e       ft_q;
  logic [ADDR_W-1:0] victim_q, aggr_q;
  logic [1:0]        fbit_q;
  logic [DATA_W-1:0] vmask;

  logic              busy, accept, wr_acc, rd_acc;
  logic              arr_we, v_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_din, arr_dout, v_din, v_dout, rd_word;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_INIT: begin
        idx_nxt = idx + 1'b1;
        if (idx == '1) state_nxt = ST_IDLE;
      end
      default: idx_nxt = '0;
    endcase
  end

  assign busy   = (state == ST_INIT);
  assign accept = (state == ST_IDLE) && bus.mem_en;
  assign wr_acc = accept && bus.wr_en;
  assign rd_acc = accept && !bus.wr_en;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ft_q     <= FT_NONE;
      victim_q <= '0;
      fbit_q   <= '0;
      aggr_q   <= '0;
    end else if (fault_load && state == ST_IDLE) begin
      ft_q     <= fault_type_e'(fault_type);
      victim_q <= fault_addr;
      fbit_q   <= fault_bit;
      aggr_q   <= aggr_addr;
    end
  end

  always_comb begin
    vmask         = '0;
    vmask[fbit_q] = 1'b1;
  end

  // Write path: fault effects are folded into the stored data (read-modify-write).
  always_comb begin
    arr_we   = 1'b0;
    arr_addr = bus.addr;
    arr_din  = bus.data_in;
    v_we     = 1'b0;
    v_din    = v_dout ^ vmask;
    if (busy) begin
      arr_we   = 1'b1;
      arr_addr = idx;
      arr_din  = '0;
    end else if (wr_acc) begin
      arr_we = 1'b1;
      if (bus.addr == victim_q) begin
        case (ft_q)
          FT_SA0:  arr_din = bus.data_in & ~vmask;
          FT_SA1:  arr_din = bus.data_in | vmask;
          FT_TFUP: if ((arr_dout & vmask) == '0) arr_din = bus.data_in & ~vmask;
          default: arr_din = bus.data_in;
        endcase
      end
      if (ft_q == FT_CFIN && bus.addr == aggr_q && aggr_q != victim_q &&
          ((arr_dout ^ bus.data_in) & vmask) != '0)
        v_we = 1'b1;
    end
  end

  sram_fault_responder_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk_sys (clk_sys),
    .we      (arr_we),
    .addr    (arr_addr),
    .din     (arr_din),
    .dout    (arr_dout),
    .vwe     (v_we),
    .vaddr   (victim_q),
    .vdin    (v_din),
    .vdout   (v_dout)
  );

  // Stuck-at cells also read stuck, covering contents left over from before the fault load.
  always_comb begin
    rd_word = arr_dout;
    if (bus.addr == victim_q) begin
      if (ft_q == FT_SA0) rd_word = arr_dout & ~vmask;
      if (ft_q == FT_SA1) rd_word = arr_dout | vmask;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) data_out_q <= rd_word;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_acc && wr_count != '1) wr_count <= wr_count + 1'b1;
      if (rd_acc && rd_count != '1) rd_count <= rd_count + 1'b1;
    end
  end

  assign bus.busy     = busy;
  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_sram_fault_responder.sv
// Scoreboard bench for sram_fault_responder: clear sweep, fault models, March C- and counters.
module tb_sram_fault_responder;
  import sram_fault_responder_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 4;
  localparam int CW  = 11;
  localparam int MAXC = (1 << CW) - 1;

  logic clk_sys = 1'b0;
  logic rst;
  always #5 clk_sys = ~clk_sys;

  sram_fault_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          fault_load;
  logic [2:0]    fault_type;
  logic [AW-1:0] fault_addr, aggr_addr;
  logic [1:0]    fault_bit;
  logic [CW-1:0] wr_count, rd_count;

  sram_fault_responder #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1), .CNT_W(CW)) u_dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .bus        (bus),
    .fault_load (fault_load),
    .fault_type (fault_type),
    .fault_addr (fault_addr),
    .fault_bit  (fault_bit),
    .aggr_addr  (aggr_addr),
    .wr_count   (wr_count),
    .rd_count   (rd_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    bit            march;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_wr = 0;
  int   exp_rd = 0;
  bit   march_fail;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Read responses are matched against the scoreboard, including the one-cycle latency.
  always @(negedge clk_sys) begin : monitor
    exp_t e;
    if (bus.rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rd_valid data_out=%h, no read outstanding", bus.data_out);
      end else begin
        e = sb_q.pop_front();
        if (e.march) begin
          if (bus.data_out !== e.data || cyc != e.cyc) march_fail = 1'b1;
        end else begin
          checks++;
          if (bus.data_out !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL read_data got=%h at cycle %0d, expected=%h at cycle %0d",
                     bus.data_out, cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout, simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic acc(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] exp_data, input bit march);
    bus.mem_en  = 1'b1;
    bus.wr_en   = we;
    bus.addr    = a;
    bus.data_in = d;
    if (!bus.busy) begin
      if (we) exp_wr = (exp_wr < MAXC) ? exp_wr + 1 : exp_wr;
      else begin
        exp_rd = (exp_rd < MAXC) ? exp_rd + 1 : exp_rd;
        sb_q.push_back('{exp_data, cyc + 1, march});
      end
    end
    @(posedge clk_sys);
    #1;
    bus.mem_en = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    acc(1'b1, a, d, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    acc(1'b0, a, '0, e, 1'b0);
  endtask

  task automatic load_fault(input logic [2:0] t, input logic [AW-1:0] va,
                            input logic [1:0] b, input logic [AW-1:0] aa);
    fault_type = t;
    fault_addr = va;
    fault_bit  = b;
    aggr_addr  = aa;
    fault_load = 1'b1;
    @(posedge clk_sys);
    #1;
    fault_load = 1'b0;
  endtask

  task automatic do_reset(output int n);
    rst = 1'b1;
    sb_q.delete();
    exp_wr = 0;
    exp_rd = 0;
    idle(3);
    rst = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      idle(1);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    sb_q.delete();
    exp_wr = 0;
    exp_rd = 0;
    idle(3);
    checks++;
    if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0 || bus.data_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b rd_valid=%b data_out=%h, expected 1 0 0",
               bus.busy, bus.rd_valid, bus.data_out);
    end
    checks++;
    if (wr_count !== '0 || rd_count !== '0) begin
      errors++;
      $display("FAIL reset_counters wr=%0d rd=%0d, expected 0 0", wr_count, rd_count);
    end
    rst = 1'b0;
    n = 0;
    wr(8'h77, 4'h5);
    n++;
    rd(8'h77, 4'h0);
    n++;
    load_fault(3'(FT_SA1), 8'h30, 2'd0, 8'h00);
    n++;
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      idle(1);
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL busy_cycles got=%0d, expected=256", n);
    end
    checks++;
    if (wr_count !== '0 || rd_count !== '0) begin
      errors++;
      $display("FAIL busy_not_counted wr=%0d rd=%0d, expected 0 0", wr_count, rd_count);
    end
    for (int i = 0; i < 256; i++) rd(AW'(i), 4'h0);
    idle(2);
    checks++;
    if (rd_count !== CW'(256) || sb_q.size() != 0) begin
      errors++;
      $display("FAIL sweep_reads rd_count=%0d pending=%0d, expected 256 0", rd_count, sb_q.size());
    end
  endtask

  task automatic test_basic();
    int n;
    do_reset(n);
    wr(8'h3C, 4'hA);
    rd(8'h3C, 4'hA);
    idle(2);
    checks++;
    if (wr_count !== CW'(1) || rd_count !== CW'(1)) begin
      errors++;
      $display("FAIL basic_counts wr=%0d rd=%0d, expected 1 1", wr_count, rd_count);
    end
    wr(8'h00, 4'h5);
    wr(8'hFF, 4'hC);
    rd(8'hFF, 4'hC);
    rd(8'h00, 4'h5);
    rd(8'h3C, 4'hA);
    wr(8'h3C, 4'h3);
    rd(8'h3C, 4'h3);
    idle(3);
    checks++;
    if (bus.data_out !== 4'h3 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL data_out_hold data_out=%h rd_valid=%b, expected 3 0", bus.data_out, bus.rd_valid);
    end
    checks++;
    if (wr_count !== CW'(exp_wr) || rd_count !== CW'(exp_rd) || sb_q.size() != 0) begin
      errors++;
      $display("FAIL basic_totals wr=%0d rd=%0d, expected %0d %0d", wr_count, rd_count, exp_wr, exp_rd);
    end
  endtask

  task automatic test_stuck_at();
    load_fault(3'(FT_SA0), 8'h10, 2'd2, 8'h00);
    wr(8'h10, 4'hF);
    rd(8'h10, 4'hB);
    wr(8'h11, 4'hF);
    rd(8'h11, 4'hF);
    wr(8'h10, 4'h0);
    rd(8'h10, 4'h0);
    load_fault(3'(FT_SA1), 8'h10, 2'd0, 8'h00);
    rd(8'h10, 4'h1);
    load_fault(3'(FT_NONE), 8'h10, 2'd0, 8'h00);
    rd(8'h10, 4'h0);
    load_fault(3'(FT_SA0), 8'h12, 2'd3, 8'h00);
    wr(8'h12, 4'hF);
    load_fault(3'(FT_NONE), 8'h00, 2'd0, 8'h00);
    rd(8'h12, 4'h7);
    idle(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sa_pending got=%0d, expected=0", sb_q.size());
    end
  endtask

  task automatic test_transition();
    load_fault(3'(FT_TFUP), 8'h20, 2'd0, 8'h00);
    wr(8'h20, 4'h0);
    wr(8'h20, 4'h1);
    rd(8'h20, 4'h0);
    wr(8'h20, 4'hF);
    rd(8'h20, 4'hE);
    load_fault(3'(FT_NONE), 8'h00, 2'd0, 8'h00);
    wr(8'h20, 4'h1);
    rd(8'h20, 4'h1);
    load_fault(3'(FT_TFUP), 8'h20, 2'd0, 8'h00);
    wr(8'h20, 4'h0);
    rd(8'h20, 4'h0);
    wr(8'h20, 4'h1);
    rd(8'h20, 4'h0);
    idle(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL tf_pending got=%0d, expected=0", sb_q.size());
    end
  endtask

  task automatic test_load_timing();
    load_fault(3'(FT_NONE), 8'h00, 2'd0, 8'h00);
    wr(8'h41, 4'h0);
    fault_type = 3'(FT_TFUP);
    fault_addr = 8'h41;
    fault_bit  = 2'd0;
    aggr_addr  = 8'h00;
    fault_load = 1'b1;
    wr(8'h41, 4'h1);
    fault_load = 1'b0;
    rd(8'h41, 4'h1);
    wr(8'h41, 4'h0);
    wr(8'h41, 4'h1);
    rd(8'h41, 4'h0);
    idle(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL load_timing_pending got=%0d, expected=0", sb_q.size());
    end
  endtask

  task automatic test_coupling();
    load_fault(3'(FT_CFIN), 8'h06, 2'd1, 8'h05);
    wr(8'h06, 4'h0);
    wr(8'h05, 4'h0);
    wr(8'h05, 4'h2);
    rd(8'h06, 4'h2);
    rd(8'h05, 4'h2);
    wr(8'h05, 4'h3);
    rd(8'h06, 4'h2);
    wr(8'h05, 4'h0);
    rd(8'h06, 4'h0);
    wr(8'h06, 4'hC);
    wr(8'h05, 4'h2);
    rd(8'h06, 4'hE);
    load_fault(3'(FT_CFIN), 8'h50, 2'd0, 8'h50);
    wr(8'h50, 4'h0);
    wr(8'h50, 4'h1);
    rd(8'h50, 4'h1);
    idle(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL cfin_pending got=%0d, expected=0", sb_q.size());
    end
  endtask

  task automatic test_march(input bit inject, input bit exp_fail);
    int n;
    do_reset(n);
    if (inject) load_fault(3'(FT_SA1), 8'hFF, 2'd3, 8'h00);
    march_fail = 1'b0;
    for (int i = 0; i < 256; i++) acc(1'b1, AW'(i), 4'h0, '0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      acc(1'b0, AW'(i), '0, 4'h0, 1'b1);
      acc(1'b1, AW'(i), 4'hF, '0, 1'b0);
    end
    for (int i = 0; i < 256; i++) begin
      acc(1'b0, AW'(i), '0, 4'hF, 1'b1);
      acc(1'b1, AW'(i), 4'h0, '0, 1'b0);
    end
    for (int i = 255; i >= 0; i--) begin
      acc(1'b0, AW'(i), '0, 4'h0, 1'b1);
      acc(1'b1, AW'(i), 4'hF, '0, 1'b0);
    end
    for (int i = 255; i >= 0; i--) begin
      acc(1'b0, AW'(i), '0, 4'hF, 1'b1);
      acc(1'b1, AW'(i), 4'h0, '0, 1'b0);
    end
    for (int i = 0; i < 256; i++) acc(1'b0, AW'(i), '0, 4'h0, 1'b1);
    idle(2);
    checks++;
    if (march_fail !== exp_fail || sb_q.size() != 0) begin
      errors++;
      $display("FAIL march_gonogo fail=%b pending=%0d, expected fail=%b pending=0",
               march_fail, sb_q.size(), exp_fail);
    end
    checks++;
    if (wr_count !== CW'(1280) || rd_count !== CW'(1280)) begin
      errors++;
      $display("FAIL march_counts wr=%0d rd=%0d, expected 1280 1280", wr_count, rd_count);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(n);
    for (int i = 0; i < 100; i++) wr(AW'(i), 4'h9);
    checks++;
    if (wr_count !== CW'(100)) begin
      errors++;
      $display("FAIL mid_precount wr=%0d, expected 100", wr_count);
    end
    rst = 1'b1;
    idle(1);
    checks++;
    if (bus.busy !== 1'b1 || wr_count !== '0 || rd_count !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%b wr=%0d rd=%0d, expected 1 0 0", bus.busy, wr_count, rd_count);
    end
    rst = 1'b0;
    exp_wr = 0;
    exp_rd = 0;
    n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      idle(1);
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL mid_busy_cycles got=%0d, expected=256", n);
    end
    rd(8'h05, 4'h0);
    idle(2);
  endtask

  task automatic test_saturate();
    int n;
    do_reset(n);
    for (int i = 0; i < MAXC + 5; i++) wr(AW'(i), AW'(i) % 16);
    rd(8'h03, 4'h3);
    rd(8'h04, 4'h4);
    idle(2);
    checks++;
    if (wr_count !== CW'(MAXC) || wr_count !== CW'(exp_wr)) begin
      errors++;
      $display("FAIL wr_saturate got=%0d, expected=%0d", wr_count, MAXC);
    end
    checks++;
    if (rd_count !== CW'(2)) begin
      errors++;
      $display("FAIL rd_after_sat got=%0d, expected=2", rd_count);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.mem_en  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    fault_load  = 1'b0;
    fault_type  = '0;
    fault_addr  = '0;
    fault_bit   = '0;
    aggr_addr   = '0;
    test_reset();
    test_basic();
    test_stuck_at();
    test_transition();
    test_load_timing();
    test_coupling();
    test_march(1'b0, 1'b0);
    test_march(1'b1, 1'b1);
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
